// File: rtl/pin_mux_ctrl_if.sv
// pin_mux_ctrl_if: select, PIO, peripheral, pad and interrupt signals of pin_mux_ctrl.
// master = SoC/pad side that drives the requests, slave = the pin multiplexer.
interface pin_mux_ctrl_if #(
  parameter int PINS  = 32,
  parameter int FUNCS = 4,
  parameter int SEL_W = $clog2(FUNCS)
);
  logic [PINS*SEL_W-1:0]     iMSEL;
  logic [PINS-1:0]           iPIO_OUT;
  logic [PINS-1:0]           iPIO_DIR;
  logic [PINS*(FUNCS-1)-1:0] iALT_OUT;
  logic [PINS*(FUNCS-1)-1:0] iALT_OE;
  logic [PINS-1:0]           iPAD_IN;
  logic [PINS-1:0]           oPAD_OUT;
  logic [PINS-1:0]           oPAD_OE;
  logic [PINS-1:0]           oPIO_IN;
  logic [PINS-1:0]           oSWITCHING;
  logic [PINS-1:0]           iIRQ_RISE_EN;
  logic [PINS-1:0]           iIRQ_FALL_EN;
  logic [PINS-1:0]           iIRQ_CLR;
  logic [PINS-1:0]           oIRQ_PEND;
  logic                      oIRQ;

  modport master (
    output iMSEL, iPIO_OUT, iPIO_DIR, iALT_OUT, iALT_OE, iPAD_IN,
    output iIRQ_RISE_EN, iIRQ_FALL_EN, iIRQ_CLR,
    input  oPAD_OUT, oPAD_OE, oPIO_IN, oSWITCHING, oIRQ_PEND, oIRQ
  );

  modport slave (
    input  iMSEL, iPIO_OUT, iPIO_DIR, iALT_OUT, iALT_OE, iPAD_IN,
    input  iIRQ_RISE_EN, iIRQ_FALL_EN, iIRQ_CLR,
    output oPAD_OUT, oPAD_OE, oPIO_IN, oSWITCHING, oIRQ_PEND, oIRQ
  );
endinterface

// File: rtl/pin_mux_ctrl.sv
// pin_mux_ctrl: per-pin function mux with a guaranteed hi-Z gap on every select change,
// a pad input synchroniser and optional edge interrupts built when PINMUX_IRQ_EN is defined.
module pin_mux_ctrl #(
  parameter int PINS  = 32,
  parameter int FUNCS = 4,
  parameter int SEL_W = $clog2(FUNCS),
  parameter int GAP   = 4
) (
  input  logic          iCLK,
  input  logic          iRESETn,
  pin_mux_ctrl_if.slave bus
);

  typedef enum logic {ST_ACTIVE = 1'b0, ST_GAP = 1'b1} state_t;

  localparam logic [3:0] GAP_CNT = 4'(GAP);

  // Returns {oe, out} for a select value; out-of-range selects float the pin.
  function automatic logic [1:0] driveOf(
    input logic [SEL_W-1:0] sel,
    input logic [FUNCS-1:0] oeVec,
    input logic [FUNCS-1:0] outVec
  );
    logic oeBit;
    logic outBit;
    oeBit  = 1'b0;
    outBit = 1'b0;
    for (int f = 0; f < FUNCS; f++) begin
      oeBit  = oeBit  | ((sel == SEL_W'(f)) & oeVec[f]);
      outBit = outBit | ((sel == SEL_W'(f)) & oeVec[f] & outVec[f]);
    end
    return {oeBit, outBit};
  endfunction

  for (genvar p = 0; p < PINS; p++) begin : gPin
    state_t           state_r;
    logic [3:0]       cnt_r;
    logic [SEL_W-1:0] act_r;
    logic             padOe_r;
    logic             padOut_r;
    logic             switching_r;
    logic [SEL_W-1:0] req_s;
    logic [FUNCS-1:0] fnOe_s;
    logic [FUNCS-1:0] fnOut_s;

    assign req_s = bus.iMSEL[p*SEL_W +: SEL_W];

    // Gather this pin's candidate drivers; index 0 is the PIO core.
    always_comb begin
      fnOe_s     = {FUNCS{1'b0}};
      fnOut_s    = {FUNCS{1'b0}};
      fnOe_s[0]  = bus.iPIO_DIR[p];
      fnOut_s[0] = bus.iPIO_OUT[p];
      for (int f = 1; f < FUNCS; f++) begin
        fnOe_s[f]  = bus.iALT_OE[(f-1)*PINS + p];
        fnOut_s[f] = bus.iALT_OUT[(f-1)*PINS + p];
      end
    end

    // Switch FSM; pad drive is registered from the next-state function selection.
    always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
        state_r     <= ST_ACTIVE;
        cnt_r       <= 4'd0;
        act_r       <= {SEL_W{1'b0}};
        padOe_r     <= 1'b0;
        padOut_r    <= 1'b0;
        switching_r <= 1'b0;
      end else begin
        case (state_r)
          ST_ACTIVE: begin
            if (req_s == act_r) begin
              {padOe_r, padOut_r} <= driveOf(act_r, fnOe_s, fnOut_s);
              switching_r         <= 1'b0;
            end else if (GAP == 0) begin
              act_r               <= req_s;
              {padOe_r, padOut_r} <= driveOf(req_s, fnOe_s, fnOut_s);
              switching_r         <= 1'b0;
            end else begin
              state_r     <= ST_GAP;
              cnt_r       <= GAP_CNT;
              padOe_r     <= 1'b0;
              padOut_r    <= 1'b0;
              switching_r <= 1'b1;
            end
          end
          ST_GAP: begin
            // The select seen on the final gap cycle wins; earlier changes are ignored.
            if (cnt_r <= 4'd1) begin
              state_r             <= ST_ACTIVE;
              cnt_r               <= 4'd0;
              act_r               <= req_s;
              {padOe_r, padOut_r} <= driveOf(req_s, fnOe_s, fnOut_s);
              switching_r         <= 1'b0;
            end else begin
              cnt_r       <= cnt_r - 4'd1;
              padOe_r     <= 1'b0;
              padOut_r    <= 1'b0;
              switching_r <= 1'b1;
            end
          end
          default: begin
            state_r     <= ST_ACTIVE;
            cnt_r       <= 4'd0;
            act_r       <= {SEL_W{1'b0}};
            padOe_r     <= 1'b0;
            padOut_r    <= 1'b0;
            switching_r <= 1'b0;
          end
        endcase
      end
    end

    assign bus.oPAD_OE[p]    = padOe_r;
    assign bus.oPAD_OUT[p]   = padOut_r;
    assign bus.oSWITCHING[p] = switching_r;
  end

  logic [PINS-1:0] sync1_r;
  logic [PINS-1:0] sync2_r;

  // Two-flop synchroniser for the asynchronous pad inputs.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      sync1_r <= {PINS{1'b0}};
      sync2_r <= {PINS{1'b0}};
    end else begin
      sync1_r <= bus.iPAD_IN;
      sync2_r <= sync1_r;
    end
  end

  assign bus.oPIO_IN = sync2_r;

`ifdef PINMUX_IRQ_EN
  logic [PINS-1:0] sync3_r;
  logic [PINS-1:0] pend_r;
  logic [PINS-1:0] hit_s;

  assign hit_s = (sync2_r & ~sync3_r & bus.iIRQ_RISE_EN) |
                 (~sync2_r & sync3_r & bus.iIRQ_FALL_EN);

  // Edge-detect tap and pending flags; a new edge beats a same-cycle clear.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      sync3_r <= {PINS{1'b0}};
      pend_r  <= {PINS{1'b0}};
    end else begin
      sync3_r <= sync2_r;
      pend_r  <= hit_s | (pend_r & ~bus.iIRQ_CLR);
    end
  end

  assign bus.oIRQ_PEND = pend_r;
  assign bus.oIRQ      = |pend_r;
`else
  logic unusedIrq_s;

  assign unusedIrq_s   = ^{bus.iIRQ_RISE_EN, bus.iIRQ_FALL_EN, bus.iIRQ_CLR};
  assign bus.oIRQ_PEND = {PINS{1'b0}};
  assign bus.oIRQ      = 1'b0;
`endif

endmodule
